// File: rtl/hidden_neuron_forward.sv
// rtl/hidden_neuron_forward.sv - forward-pass hidden-layer neuron (MAC, /1000 scale, sigmoid-like activation)
//
// Purpose: accepts N_INPUTS signed in_val/weight pairs one beat at a time,
// multiply-accumulates them, scales the sum by 1/1000 (truncating toward zero)
// and applies f(X) = 0.5[X/(1+|X|)+1] in thousandths using a 9-step restoring
// divider. Optional feature macro: HIDDEN_NEURON_SAT_EN (saturate the scaled
// sum to [-512, 511]; otherwise it wraps to its low 10 bits).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input pair present          in_ready  pair accepted this cycle
//   in_val     signed input (thousandths)  weight    signed weight (thousandths)
//   out_valid  result held and stable      out_ready consumer takes the result
//   out_act    activation, 0..1000         out_net   signed scaled pre-activation sum
module hidden_neuron_forward #(
  parameter int N_INPUTS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [9:0] in_val,
  input  logic signed [9:0] weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic        [9:0] out_act,
  output logic signed [9:0] out_net
);

  typedef enum logic [2:0] {IDLE, ACCUM, SCALE, DIVIDE, DONE} state_t;

  localparam logic [4:0] LAST_BEAT = 5'(N_INPUTS - 1);

  state_t             state_q, state_d;
  logic signed [23:0] acc_q, acc_d;
  logic        [4:0]  cnt_q, cnt_d;
  logic        [10:0] rem_q, rem_d;
  logic        [8:0]  quo_q, quo_d;
  logic        [10:0] den_q, den_d;
  logic               neg_q, neg_d;
  logic signed [9:0]  net_q, net_d;
  logic        [9:0]  act_q, act_d;
  logic               valid_q, valid_d;

  logic signed [19:0] prod;
  logic               beat;
  logic signed [23:0] quot;
  logic signed [9:0]  net_scaled;
  logic        [9:0]  abs_net;
  logic        [17:0] num;
  logic        [10:0] den;
  logic        [11:0] trial;
  logic               ge;

  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign beat      = in_valid && in_ready;
  assign prod      = in_val * weight;
  // Signed division truncates toward zero, which is the required rounding.
  assign quot      = acc_q / 24'sd1000;
  assign out_valid = valid_q;
  assign out_act   = act_q;
  assign out_net   = net_q;

  always_comb begin
    net_scaled = quot[9:0];
`ifdef HIDDEN_NEURON_SAT_EN
    if (quot > 24'sd511) begin
      net_scaled = 10'sd511;
    end else if (quot < -24'sd512) begin
      net_scaled = -10'sd512;
    end
`endif
  end

  // |-512| = 512 still fits as a 10-bit unsigned magnitude.
  assign abs_net = net_scaled[9] ? (~net_scaled + 10'd1) : net_scaled;
  assign num     = 18'(abs_net) * 18'd500;
  assign den     = 11'd1000 + 11'(abs_net);

  // Quotient is always < 512, so num[17:9] < den and can seed the remainder;
  // the remaining 9 numerator bits sit in quo_q and shift out as quotient
  // bits shift in.
  assign trial = {rem_q, quo_q[8]};
  assign ge    = trial >= {1'b0, den_q};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    den_d   = den_q;
    neg_d   = neg_q;
    net_d   = net_q;
    act_d   = act_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (beat) begin
          acc_d   = 24'(prod);
          cnt_d   = 5'd1;
          state_d = (N_INPUTS == 1) ? SCALE : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = acc_q + 24'(prod);
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST_BEAT) state_d = SCALE;
        end
      end
      SCALE: begin
        net_d   = net_scaled;
        neg_d   = net_scaled[9];
        rem_d   = {2'b00, num[17:9]};
        quo_d   = num[8:0];
        den_d   = den;
        cnt_d   = '0;
        state_d = DIVIDE;
      end
      DIVIDE: begin
        rem_d = ge ? 11'(trial - {1'b0, den_q}) : trial[10:0];
        quo_d = {quo_q[7:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd8) state_d = DONE;
      end
      DONE: begin
        // First DONE cycle registers the activation; then hold for the consumer.
        if (!valid_q) begin
          valid_d = 1'b1;
          act_d   = neg_q ? (10'd500 - 10'(quo_q)) : (10'd500 + 10'(quo_q));
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      den_q   <= '0;
      neg_q   <= 1'b0;
      net_q   <= '0;
      act_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      den_q   <= den_d;
      neg_q   <= neg_d;
      net_q   <= net_d;
      act_q   <= act_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_hidden_neuron_forward.sv
// tb/tb_hidden_neuron_forward.sv - self-checking bench for hidden_neuron_forward
module tb_hidden_neuron_forward;

  localparam int N = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [9:0] in_val;
  logic signed [9:0] weight;
  logic              out_valid;
  logic              out_ready;
  logic        [9:0] out_act;
  logic signed [9:0] out_net;

  int tests = 0;
  int fails = 0;
  int vec_v[N];
  int vec_w[N];

  hidden_neuron_forward #(.N_INPUTS(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val), .weight(weight),
    .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act), .out_net(out_net)
  );

  always #5 clk = ~clk;

  function automatic void model(output int net, output int act);
    int sum, m, a, q;
    sum = 0;
    for (int i = 0; i < N; i++) sum += vec_v[i] * vec_w[i];
    net = sum / 1000;
`ifdef HIDDEN_NEURON_SAT_EN
    if (net > 511) net = 511;
    if (net < -512) net = -512;
`else
    m = net % 1024;
    if (m < 0) m += 1024;
    net = (m >= 512) ? m - 1024 : m;
`endif
    a = (net < 0) ? -net : net;
    q = (500 * a) / (1000 + a);
    act = (net < 0) ? 500 - q : 500 + q;
  endfunction

  task automatic clear_vec();
    for (int i = 0; i < N; i++) begin vec_v[i] = 0; vec_w[i] = 0; end
  endtask

  task automatic random_vec();
    for (int i = 0; i < N; i++) begin
      vec_v[i] = int'($urandom_range(0, 1023)) - 512;
      vec_w[i] = int'($urandom_range(0, 1023)) - 512;
    end
  endtask

  // Stimulus only: streams vec_v/vec_w, then waits (bounded) for out_valid.
  task automatic drive_vector(input bit gaps, output int lat, output int net_o, output int act_o);
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin in_valid = 1'b0; @(posedge clk); #1; end
      in_valid = 1'b1;
      in_val   = 10'(vec_v[i]);
      weight   = 10'(vec_w[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    net_o = int'(out_net);
    act_o = int'(out_act);
  endtask

  task automatic handshake();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_val = '0; weight = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (out_act !== 10'd0) begin fails++; $display("FAIL reset_out_act: got %0d expected 0", out_act); end
    tests++; if (out_net !== 10'sd0) begin fails++; $display("FAIL reset_out_net: got %0d expected 0", out_net); end
  endtask

  task automatic test_directed();
    int lat, n, a;
    int exp_net[4] = '{0, 250, -250, -2};
    int exp_act[4] = '{500, 600, 400, 500};
    for (int t = 0; t < 4; t++) begin
      clear_vec();
      if (t == 1) begin vec_v[0] = 500;  vec_w[0] = 500; end
      if (t == 2) begin vec_v[0] = -500; vec_w[0] = 500; end
      if (t == 3) begin vec_v[0] = -43;  vec_w[0] = 47;  end
      drive_vector(1'b0, lat, n, a);
      tests++; if (lat !== 11) begin fails++; $display("FAIL directed%0d_latency: got %0d expected 11", t, lat); end
      tests++; if (n !== exp_net[t]) begin fails++; $display("FAIL directed%0d_net: got %0d expected %0d", t, n, exp_net[t]); end
      tests++; if (a !== exp_act[t]) begin fails++; $display("FAIL directed%0d_act: got %0d expected %0d", t, a, exp_act[t]); end
      handshake();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL directed%0d_release: got %b expected 0", t, out_valid); end
    end
  endtask

  task automatic test_saturation();
    int lat, n, a, en, ea;
`ifdef HIDDEN_NEURON_SAT_EN
    en = 511;  ea = 669;
`else
    en = -461; ea = 343;
`endif
    for (int i = 0; i < N; i++) begin vec_v[i] = 511; vec_w[i] = 511; end
    drive_vector(1'b0, lat, n, a);
    tests++; if (n !== en) begin fails++; $display("FAIL big_net: got %0d expected %0d", n, en); end
    tests++; if (a !== ea) begin fails++; $display("FAIL big_act: got %0d expected %0d", a, ea); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat, n, a, en, ea;
    random_vec();
    model(en, ea);
    drive_vector(1'b1, lat, n, a);
    tests++; if (n !== en || a !== ea) begin fails++; $display("FAIL bp_result: got %0d/%0d expected %0d/%0d", n, a, en, ea); end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_val   = 10'($urandom_range(0, 1023));
      weight   = 10'($urandom_range(0, 1023));
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(out_net) !== en || int'(out_act) !== ea) begin
        fails++;
        $display("FAIL bp_hold%0d: got v=%b r=%b %0d/%0d expected v=1 r=0 %0d/%0d", c, out_valid, in_ready, out_net, out_act, en, ea);
      end
      @(posedge clk); #1;
    end
    handshake();
    random_vec();
    model(en, ea);
    drive_vector(1'b1, lat, n, a);
    tests++; if (lat !== 11 || n !== en || a !== ea) begin fails++; $display("FAIL bp_next: got lat=%0d %0d/%0d expected lat=11 %0d/%0d", lat, n, a, en, ea); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat, n, a, seen;
    random_vec();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_val = 10'(vec_v[i]); weight = 10'(vec_w[i]);
      @(posedge clk); #1;
    end
    // Reset coincides with an offered beat: the beat must be dropped.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL midreset_state: got r=%b v=%b expected r=1 v=0", in_ready, out_valid); end
    clear_vec();
    vec_v[0] = 500; vec_w[0] = 500;
    drive_vector(1'b0, lat, n, a);
    tests++; if (lat !== 11 || n !== 250 || a !== 600) begin fails++; $display("FAIL midreset_vec: got lat=%0d %0d/%0d expected lat=11 250/600", lat, n, a); end
    handshake();
    // Abort during DIVIDE: no result may ever appear.
    random_vec();
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_val = 10'(vec_v[i]); weight = 10'(vec_w[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (20) begin if (out_valid) seen++; @(posedge clk); #1; end
    tests++; if (seen !== 0 || out_net !== 10'sd0) begin fails++; $display("FAIL divreset_no_output: got valid_cycles=%0d net=%0d expected 0/0", seen, out_net); end
  endtask

  task automatic test_random();
    int lat, n, a, en, ea;
    for (int t = 0; t < 12; t++) begin
      random_vec();
      model(en, ea);
      drive_vector(t[0], lat, n, a);
      tests++; if (lat !== 11) begin fails++; $display("FAIL rand%0d_latency: got %0d expected 11", t, lat); end
      tests++; if (n !== en || a !== ea) begin fails++; $display("FAIL rand%0d_result: got %0d/%0d expected %0d/%0d", t, n, a, en, ea); end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
